// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with 4-word line refill from main memory.
// Optional hit/miss performance counters are built when ICACHE_PERF_CNT_EN is defined.
module icache #(
    parameter int unsigned NUM_LINES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);

    localparam int unsigned INDEX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W   = 28 - INDEX_W;
    localparam int unsigned LINE_W  = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LADDR_W = 28;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ALLOC = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];
    logic [LADDR_W-1:0]   miss_addr_q, miss_addr_d;
    logic                 mem_read_q, mem_read_d;
    logic                 fill_en;
    logic                 miss_start;

    logic [INDEX_W-1:0]   req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [1:0]           req_off;
    logic                 hit;
    logic [LINE_W-1:0]    rd_line;
    logic [INDEX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]     fill_tag;
    logic                 unused_c;

    // Address decode and combinational lookup
    assign req_off  = proc_addr[1:0];
    assign req_idx  = proc_addr[INDEX_W+1:2];
    assign req_tag  = proc_addr[29:INDEX_W+2];
    assign hit      = proc_read & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign rd_line  = data_q[req_idx];
    assign proc_rdata = rd_line[{req_off, 5'd0} +: WORD_W];

    assign fill_idx = miss_addr_q[INDEX_W-1:0];
    assign fill_tag = miss_addr_q[LADDR_W-1:INDEX_W];

    // Read-only cache: no store path toward memory
    assign mem_write = 1'b0;
    assign mem_wdata = '0;
    assign mem_read  = mem_read_q;
    assign mem_addr  = miss_addr_q;
    assign unused_c  = ^{proc_write, proc_wdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            mem_read_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            mem_read_q  <= mem_read_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        mem_read_d  = mem_read_q;
        fill_en     = 1'b0;
        miss_start  = 1'b0;
        proc_stall  = 1'b0;
        case (state_q)
            IDLE: begin
                proc_stall = proc_read & ~hit;
                if (proc_read && !hit) begin
                    state_d     = ALLOC;
                    miss_addr_d = proc_addr[29:2];
                    mem_read_d  = 1'b1;
                    miss_start  = 1'b1;
                end
            end
            ALLOC: begin
                // Fill always completes on the latched line, even after a redirect
                proc_stall = 1'b1;
                if (mem_ready) begin
                    fill_en    = 1'b1;
                    mem_read_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                mem_read_d = 1'b0;
            end
        endcase
    end

    // Line storage; reset clears everything so an interrupted fill is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '{default: '0};
            data_q  <= '{default: '0};
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
            tag_q[fill_idx]   <= fill_tag;
            data_q[fill_idx]  <= mem_rdata;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Saturating hit/miss counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if ((state_q == IDLE) && hit && (hit_cnt_q != 32'hFFFF_FFFF))
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (NUM_LINES=8); counter checks when ICACHE_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module tb_icache;

    logic         clk;
    logic         rst_n;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int errors = 0;
    int checks = 0;

    icache #(.NUM_LINES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and checks happen off the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;

        // Reset state
        tick();
        settle();
        chk("rst_mem_read",   128'(mem_read),   128'h0);
        chk("rst_mem_addr",   128'(mem_addr),   128'h0);
        chk("rst_stall_idle", 128'(proc_stall), 128'h0);
        chk("rst_rdata",      128'(proc_rdata), 128'h0);
        chk("rst_mem_write",  128'(mem_write),  128'h0);
        chk("rst_mem_wdata",  mem_wdata,        128'h0);
`ifdef ICACHE_PERF_CNT_EN
        chk("rst_hit_cnt",  128'(hit_cnt),  128'h0);
        chk("rst_miss_cnt", 128'(miss_cnt), 128'h0);
`endif
        #3 rst_n = 1'b1;

        // Test 1: cold miss on 0x4
        tick();
        proc_read = 1'b1;
        proc_addr = 30'h4;
        settle();
        chk("t1_stall_miss",   128'(proc_stall), 128'h1);
        chk("t1_memrd_idle",   128'(mem_read),   128'h0);
        tick();
        chk("t1_mem_read",     128'(mem_read),   128'h1);
        chk("t1_mem_addr",     128'(mem_addr),   128'h1);
        chk("t1_stall_alloc",  128'(proc_stall), 128'h1);
        tick();
        chk("t1_still_alloc",  128'(mem_read),   128'h1);

        // Test 2: fill, then hit on 0x4 and 0x7
        mem_rdata = {32'hD, 32'hC, 32'hB, 32'hA};
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        settle();
        chk("t2_hit_stall",    128'(proc_stall), 128'h0);
        chk("t2_hit_rdata",    128'(proc_rdata), 128'hA);
        chk("t2_memrd_done",   128'(mem_read),   128'h0);
        chk("t2_memaddr_hold", 128'(mem_addr),   128'h1);
        tick();
        proc_addr = 30'h7;
        settle();
        chk("t2_w3_stall",     128'(proc_stall), 128'h0);
        chk("t2_w3_rdata",     128'(proc_rdata), 128'hD);
        tick();
        proc_read  = 1'b0;
        proc_write = 1'b1;
        proc_wdata = 32'hDEAD_BEEF;
        proc_addr  = 30'h24;
        settle();
        chk("t2_noread_stall", 128'(proc_stall), 128'h0);
        tick();
        proc_write = 1'b0;
        tick();
        chk("t2_write_nomem",  128'(mem_read),   128'h0);
        chk("t2_write_addr",   128'(mem_addr),   128'h1);
`ifdef ICACHE_PERF_CNT_EN
        chk("t6_hit_cnt",  128'(hit_cnt),  128'h2);
        chk("t6_miss_cnt", 128'(miss_cnt), 128'h1);
`endif

        // Test 3: conflict miss on index 1
        proc_read = 1'b1;
        proc_addr = 30'h24;
        settle();
        chk("t3_conf_stall",   128'(proc_stall), 128'h1);
        tick();
        chk("t3_conf_addr",    128'(mem_addr),   128'h9);
        chk("t3_conf_read",    128'(mem_read),   128'h1);
        mem_rdata = {32'h14, 32'h13, 32'h12, 32'h11};
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        settle();
        chk("t3_hit_rdata",    128'(proc_rdata), 128'h11);
        chk("t3_hit_stall",    128'(proc_stall), 128'h0);
        tick();
        proc_addr = 30'h4;
        settle();
        chk("t3_evict_stall",  128'(proc_stall), 128'h1);
        chk("t3_evict_rdata",  128'(proc_rdata), 128'h11);
        tick();
        chk("t3_evict_addr",   128'(mem_addr),   128'h1);
        mem_rdata = {32'hD, 32'hC, 32'hB, 32'hA};
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        settle();
        chk("t3_refill_rdata", 128'(proc_rdata), 128'hA);

        // Test 4: redirect during fill of 0x40
        tick();
        proc_addr = 30'h40;
        settle();
        chk("t4_miss_stall",   128'(proc_stall), 128'h1);
        tick();
        chk("t4_mem_addr",     128'(mem_addr),   128'h10);
        proc_addr = 30'h80;
        settle();
        chk("t4_redir_stall",  128'(proc_stall), 128'h1);
        tick();
        chk("t4_redir_hold",   128'(mem_addr),   128'h10);
        mem_rdata = {32'h44, 32'h43, 32'h42, 32'h41};
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        settle();
        chk("t4_new_miss",     128'(proc_stall), 128'h1);
        chk("t4_line10_data",  128'(proc_rdata), 128'h41);
        tick();
        chk("t4_new_addr",     128'(mem_addr),   128'h20);
        chk("t4_new_read",     128'(mem_read),   128'h1);
        mem_rdata = {32'h54, 32'h53, 32'h52, 32'h51};
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        proc_addr = 30'h82;
        settle();
        chk("t4_hit_rdata",    128'(proc_rdata), 128'h53);
        chk("t4_hit_stall",    128'(proc_stall), 128'h0);

        // Test 5: asynchronous reset mid-fill
        tick();
        proc_addr = 30'h84;
        tick();
        chk("t5_alloc_read",   128'(mem_read),   128'h1);
        chk("t5_alloc_addr",   128'(mem_addr),   128'h21);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_memread",  128'(mem_read),   128'h0);
        chk("t5_rst_memaddr",  128'(mem_addr),   128'h0);
        chk("t5_rst_stall",    128'(proc_stall), 128'h1);
        chk("t5_rst_rdata",    128'(proc_rdata), 128'h0);
        proc_read = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        mem_rdata = {4{32'hFFFF_FFFF}};
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        proc_read = 1'b1;
        proc_addr = 30'h4;
        settle();
        chk("t5_stale_stall",  128'(proc_stall), 128'h1);
        chk("t5_stale_rdata",  128'(proc_rdata), 128'h0);
        chk("t5_stale_idle",   128'(mem_read),   128'h0);
        tick();
        chk("t5_remiss_read",  128'(mem_read),   128'h1);
        chk("t5_remiss_addr",  128'(mem_addr),   128'h1);
`ifdef ICACHE_PERF_CNT_EN
        chk("t5_hit_cnt",  128'(hit_cnt),  128'h0);
        chk("t5_miss_cnt", 128'(miss_cnt), 128'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
